// File: rtl/homing_sequencer_if.sv
// Signal bundle between the homing sequencer and its controller, endstop block
// and motion engine. master drives the requests/status inputs; slave is the sequencer.
interface homing_sequencer_if;
   logic        start;
   logic        cancel;
   logic [1:0]  axis;
   logic        home_polarity;
   logic [31:0] move_timeout;
   logic        es_signal;
   logic        es_changed;
   logic [63:0] es_pos;
   logic        move_done;
   logic [1:0]  mux_select;
   logic        abort_polarity;
   logic        abort_enabled;
   logic        unlock;
   logic        approach_req;
   logic        backoff_req;
   logic        busy;
   logic        done;
   logic [1:0]  error;
   logic [63:0] home_pos;

   modport master (
      output start, cancel, axis, home_polarity, move_timeout,
             es_signal, es_changed, es_pos, move_done,
      input  mux_select, abort_polarity, abort_enabled, unlock,
             approach_req, backoff_req, busy, done, error, home_pos
   );

   modport slave (
      input  start, cancel, axis, home_polarity, move_timeout,
             es_signal, es_changed, es_pos, move_done,
      output mux_select, abort_polarity, abort_enabled, unlock,
             approach_req, backoff_req, busy, done, error, home_pos
   );
endinterface

// File: rtl/homing_sequencer.sv
// Axis homing sequencer: arm endstop capture, settle, approach the switch, latch position.
// Define HOMING_BACKOFF_EN to add a back-off move after capture.
module homing_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input logic               clk,
   input logic               reset,
   homing_sequencer_if.slave hs
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SETTLE,
      APPROACH,
      CAPTURE,
`ifdef HOMING_BACKOFF_EN
      BACKOFF,
`endif
      DONE,
      FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  settle_q, settle_d;
   logic [31:0] mcnt_q, mcnt_d;
   logic [1:0]  axis_q, axis_d;
   logic        pol_q, pol_d;
   logic [1:0]  err_q, err_d;
   logic [63:0] pos_q, pos_d;

   logic        level_hit;
   logic        move_first;
   logic        timeout;

   assign level_hit  = (hs.es_signal == pol_q);
   assign move_first = (mcnt_q == '0);
   assign timeout    = (hs.move_timeout != '0) && (mcnt_q == hs.move_timeout - 32'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         settle_q <= '0;
         mcnt_q   <= '0;
         axis_q   <= '0;
         pol_q    <= 1'b0;
         err_q    <= '0;
         pos_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         mcnt_q   <= mcnt_d;
         axis_q   <= axis_d;
         pol_q    <= pol_d;
         err_q    <= err_d;
         pos_q    <= pos_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      mcnt_d   = mcnt_q;
      axis_d   = axis_q;
      pol_d    = pol_q;
      err_d    = err_q;
      pos_d    = pos_q;

      // Move-time counter saturates so a disabled timeout can never alias back to zero.
      if (mcnt_q != '1) mcnt_d = mcnt_q + 32'd1;

      if (hs.cancel) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE, FAIL: begin
               if (hs.start) begin
                  if (hs.axis == 2'd0) begin
                     state_d = FAIL;
                     err_d   = 2'd3;
                  end else begin
                     state_d = ARM;
                     axis_d  = hs.axis;
                     pol_d   = hs.home_polarity;
                     err_d   = 2'd0;
                  end
               end
            end
            ARM: begin
               settle_d = '0;
               state_d  = SETTLE;
            end
            SETTLE: begin
               if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
                  state_d = APPROACH;
                  mcnt_d  = '0;
               end else begin
                  settle_d = settle_q + 8'd1;
               end
            end
            APPROACH: begin
               // A switch already active on the first approach cycle counts as the trigger.
               if (level_hit && (hs.es_changed || move_first)) begin
                  state_d = CAPTURE;
               end else if (hs.move_done) begin
                  state_d = FAIL;
                  err_d   = 2'd2;
               end else if (timeout) begin
                  state_d = FAIL;
                  err_d   = 2'd1;
               end
            end
            CAPTURE: begin
               pos_d = hs.es_pos;
`ifdef HOMING_BACKOFF_EN
               state_d = BACKOFF;
               mcnt_d  = '0;
`else
               state_d = DONE;
`endif
            end
`ifdef HOMING_BACKOFF_EN
            BACKOFF: begin
               if (!level_hit) begin
                  state_d = DONE;
               end else if (hs.move_done) begin
                  state_d = FAIL;
                  err_d   = 2'd2;
               end else if (timeout) begin
                  state_d = FAIL;
                  err_d   = 2'd1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      hs.unlock         = (state_q == ARM);
      hs.mux_select     = axis_q;
      hs.abort_polarity = pol_q;
      hs.abort_enabled  = (state_q == ARM) || (state_q == SETTLE) || (state_q == APPROACH);
      hs.approach_req   = (state_q == APPROACH) && !(move_first && level_hit);
      hs.busy           = !((state_q == IDLE) || (state_q == DONE) || (state_q == FAIL));
      hs.done           = (state_q == DONE);
      hs.error          = err_q;
      hs.home_pos       = pos_q;
   end

`ifdef HOMING_BACKOFF_EN
   assign hs.backoff_req = (state_q == BACKOFF);
`else
   assign hs.backoff_req = 1'b0;
`endif

endmodule

// File: doc/homing_sequencer.md
HOMING_SEQUENCER -- requirements
Module: homing_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: idle cycles after endstop unlock before approach starts; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins homing; honoured only in IDLE, DONE or FAIL.
REQ-005 cancel  in  1  level; forces return to IDLE from any state.
REQ-006 axis  in  2  axis to home: 1=X, 2=Y, 3=Z; 0 is illegal.
REQ-007 home_polarity  in  1  endstop level meaning "triggered".
REQ-008 move_timeout  in  32  maximum cycles allowed in APPROACH and in BACKOFF; 0 disables the timeout.
REQ-009 es_signal / es_changed  in  1/1  debounced endstop level and its one-cycle change strobe.
REQ-010 es_pos  in  64  position captured by the endstop block at the last accepted edge.
REQ-011 move_done  in  1  pulse; motion engine finished the requested move.
REQ-012 mux_select  out  2  axis routed to endstop position capture.
REQ-013 abort_polarity / abort_enabled  out  1/1  endstop abort configuration.
REQ-014 unlock  out  1  one-cycle pulse re-arming endstop capture.
REQ-015 approach_req / backoff_req  out  1/1  level requests to the motion engine: toward the switch / away from it.
REQ-016 busy / done  out  1/1  busy is high outside IDLE, DONE and FAIL; done is high in DONE.
REQ-017 error  out  2  0=none, 1=timeout, 2=move ended without trigger, 3=illegal axis.
REQ-018 home_pos  out  64  latched es_pos of the triggering edge.

Function
REQ-019 States: IDLE, ARM, SETTLE, APPROACH, CAPTURE, BACKOFF, DONE, FAIL; encoding is free.
REQ-020 IDLE/DONE/FAIL + start with axis==0 -> FAIL, error=3, same cycle of registration; all other outputs unchanged.
REQ-021 IDLE/DONE/FAIL + start with a legal axis -> ARM; axis and home_polarity are latched; error=0; done=0.
REQ-022 ARM lasts 1 cycle: unlock=1, mux_select=latched axis, abort_polarity=latched polarity, abort_enabled=1; -> SETTLE.
REQ-023 SETTLE counts SETTLE_CYCLES cycles, then -> APPROACH; mux_select and abort outputs hold through CAPTURE.
REQ-024 APPROACH: approach_req=1. Exit priority, highest first: es_changed with es_signal==polarity -> CAPTURE; move_done -> FAIL error=2; timeout -> FAIL error=1.
REQ-025 If es_signal already equals polarity on APPROACH entry, go to CAPTURE next cycle with no approach_req pulse.
REQ-026 CAPTURE lasts 1 cycle: home_pos<=es_pos; approach_req=0; abort_enabled=0.
REQ-027 Timeout counter: 32-bit, cleared on entry to APPROACH and to BACKOFF; timeout fires on the cycle the count equals move_timeout-1; the counter never wraps.
REQ-028 DONE and FAIL hold until start or cancel; approach_req=backoff_req=0 in both states.
REQ-029 cancel has priority over every transition and over start: next state is IDLE, request outputs drop next cycle, abort_enabled=0, error and home_pos are kept.
REQ-030 Timing: approach_req rises exactly SETTLE_CYCLES+2 cycles after the start pulse is sampled.

Reset
REQ-031 Reset asserted: state IDLE; every output 0; home_pos 0; counters 0; latched axis and polarity 0.
REQ-032 Reset mid-sequence drops approach_req and backoff_req immediately (asynchronously).
REQ-033 Reset release takes effect on the first clk edge after deassertion.

Configuration
REQ-034 Macro HOMING_BACKOFF_EN defined: CAPTURE -> BACKOFF, which holds backoff_req=1 until es_signal!=polarity (-> DONE), move_done (-> FAIL error=2) or timeout (-> FAIL error=1).
REQ-035 Macro HOMING_BACKOFF_EN undefined: CAPTURE -> DONE directly, backoff_req is tied to 0, and the BACKOFF state is not built.

Verification
REQ-036 axis=2, polarity=1, SETTLE_CYCLES=16, trigger with es_pos=0x1234 -> mux_select=2, approach_req rises at cycle 18, home_pos=0x1234, done=1.
REQ-037 move_timeout=100 with no trigger -> FAIL, error=1, approach_req low after exactly 100 APPROACH cycles.
REQ-038 move_done in APPROACH on the same cycle as a trigger -> CAPTURE (trigger wins); move_done alone -> error=2.
REQ-039 start with axis=0 -> FAIL, error=3, unlock never pulses.
REQ-040 cancel in BACKOFF or APPROACH -> IDLE next cycle, both requests 0, busy=0; reset pulse mid-APPROACH -> all outputs 0.
REQ-041 HOMING_BACKOFF_EN defined: backoff_req stays high until es_signal deasserts, then done=1; macro undefined: done=1 one cycle after CAPTURE.
